// File: rtl/ml_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ml_accel_pkg
//  Purpose  : Shared definitions for ml_accel and its bus-master loader:
//             accelerator register offsets, loader state encoding and the
//             accelerator DONE state code.
//  Revision : 1.0  initial release
// ============================================================================
package ml_accel_pkg;

  // Accelerator register map (byte offsets)
  localparam logic [5:0] A_BASE = 6'h00;
  localparam logic [5:0] B_BASE = 6'h10;
  localparam logic [5:0] CTRL   = 6'h20;
  localparam logic [5:0] RESULT = 6'h24;

  // Encoding of the accelerator's own DONE state
  localparam logic [1:0] ACC_ST_DONE = 2'b10;

  // Loader sequencer states
  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_FWAIT     = 4'd2,
    ST_AWRITE    = 4'd3,
    ST_TRIGGER   = 4'd4,
    ST_WAIT_DONE = 4'd5,
    ST_RDRES     = 4'd6,
    ST_RDCAP     = 4'd7,
    ST_WBACK     = 4'd8,
    ST_FINISH    = 4'd9
  } loader_state_e;

endpackage : ml_accel_pkg
`default_nettype wire

// File: rtl/ml_accel_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ml_accel_loader
//  Purpose  : Fetches operand vectors A and B from memory, loads them into
//             ml_accel, triggers it, waits for completion (with timeout) and
//             writes the dot-product result back to memory.
//  Revision : 1.0  initial release
// ============================================================================
module ml_accel_loader
  import ml_accel_pkg::*;
#(
  parameter int VEC_LEN = 4,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [5:0]        acc_addr,
  output logic [31:0]       acc_wdata,
  output logic              acc_wen,
  output logic              acc_ren,
  input  logic [31:0]       acc_rdata,
  input  logic              acc_done
);

  localparam int K_W   = $clog2(2 * VEC_LEN + 1);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Sequencer state and datapath registers
  loader_state_e     state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0] src_a_q, src_a_d;
  logic [ADDR_W-1:0] src_b_q, src_b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [31:0]       data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [K_W-1:0]    k_inc;

  // Registered outputs
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [5:0]        acc_addr_q, acc_addr_d;
  logic [31:0]       acc_wdata_q, acc_wdata_d;
  logic              acc_wen_q, acc_wen_d;
  logic              acc_ren_q, acc_ren_d;

  assign k_inc = k_q + K_W'(1);

  // Next-state logic; outputs are derived from the next state so the
  // registered bus signals line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    dst_d       = dst_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    acc_addr_d  = '0;
    acc_wdata_d = '0;
    acc_wen_d   = 1'b0;
    acc_ren_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          src_a_d = src_a & ~ADDR_W'(3);
          src_b_d = src_b & ~ADDR_W'(3);
          dst_d   = dst & ~ADDR_W'(3);
          err_d   = 1'b0;
          k_d     = '0;
        end
      end
      ST_FETCH: begin
        if (mem_ready) state_d = ST_FWAIT;
      end
      ST_FWAIT: begin
        if (mem_rvalid) begin
          data_d  = mem_rdata;
          state_d = ST_AWRITE;
        end
      end
      ST_AWRITE: begin
        k_d     = k_inc;
        state_d = (k_inc == K_W'(2 * VEC_LEN)) ? ST_TRIGGER : ST_FETCH;
      end
      ST_TRIGGER: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (acc_done) begin
          state_d = ST_RDRES;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RDRES:  state_d = ST_RDCAP;
      ST_RDCAP: begin
        data_d  = acc_rdata;
        state_d = ST_WBACK;
      end
      ST_WBACK: begin
        if (mem_ready) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);

    case (state_d)
      ST_FETCH: begin
        mem_req_d = 1'b1;
        if (k_d < K_W'(VEC_LEN)) begin
          mem_addr_d = src_a_d + (ADDR_W'(k_d) << 2);
        end else begin
          mem_addr_d = src_b_d + (ADDR_W'(k_d - K_W'(VEC_LEN)) << 2);
        end
      end
      ST_AWRITE: begin
        acc_wen_d   = 1'b1;
        acc_wdata_d = data_d;
        if (k_d < K_W'(VEC_LEN)) begin
          acc_addr_d = A_BASE + (6'(k_d) << 2);
        end else begin
          acc_addr_d = B_BASE + (6'(k_d - K_W'(VEC_LEN)) << 2);
        end
      end
      ST_TRIGGER: begin
        acc_wen_d   = 1'b1;
        acc_addr_d  = CTRL;
        acc_wdata_d = 32'h1;
      end
      ST_RDRES: begin
        acc_ren_d  = 1'b1;
        acc_addr_d = RESULT;
      end
      ST_WBACK: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = dst_d;
        mem_wdata_d = data_d;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      acc_wen_q   <= 1'b0;
      acc_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      acc_wen_q   <= acc_wen_d;
      acc_ren_q   <= acc_ren_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign acc_addr  = acc_addr_q;
  assign acc_wdata = acc_wdata_q;
  assign acc_wen   = acc_wen_q;
  assign acc_ren   = acc_ren_q;

endmodule : ml_accel_loader
`default_nettype wire

// File: doc/ml_accel_loader.md
# ml_accel_loader

Bus-master sequencer directly upstream of `ml_accel`. On a start pulse it fetches two operand vectors (A, B) from data memory, writes them into the accelerator's operand registers, and triggers the computation. It then waits for the accelerator's done level, reads the dot-product result, and writes that result back to memory. This frees the RISC-V core from issuing the nine register writes and the result read itself.

## Interface
- `VEC_LEN`, 4: elements per vector; legal range 1..4, set by the accelerator register map.
- `ADDR_W`, 32: memory byte-address width.
- `TIMEOUT`, 255: maximum cycles spent in WAIT_DONE before aborting.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_a`  in  ADDR_W  byte address of A[0]; bits [1:0] ignored.
- `src_b`  in  ADDR_W  byte address of B[0]; bits [1:0] ignored.
- `dst`  in  ADDR_W  byte address for the result word; bits [1:0] ignored.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a job ends, whether it succeeded or failed.
- `err`  out  1  timeout flag; sticky until the next accepted `start`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  word-aligned byte address.
- `mem_wdata`  out  32  write data.
- `mem_ready`  in  1  memory accepts the request this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read data.
- `acc_addr`  out  6  accelerator register offset.
- `acc_wdata`  out  32  accelerator write data.
- `acc_wen`  out  1  accelerator write strobe.
- `acc_ren`  out  1  accelerator read strobe.
- `acc_rdata`  in  32  accelerator read data, valid the cycle after `acc_ren`.
- `acc_done`  in  1  accelerator done level (high in its DONE state).

## Operation
- Accelerator register map:
  - A[i] at 0x00 + 4i.
  - B[i] at 0x10 + 4i.
  - Control at 0x20; any write triggers computation.
  - Result at 0x24.
- FSM states: IDLE, FETCH, FWAIT, AWRITE, TRIGGER, WAIT_DONE, RDRES, RDCAP, WBACK, FINISH.
- IDLE → FETCH on `start`. Latch `src_a`/`src_b`/`dst`, clear `err`, set element index k = 0.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0.
  - `mem_addr` = `src_a` + 4k for k < VEC_LEN; otherwise `src_b` + 4(k−VEC_LEN).
  - Hold the request until `mem_ready`, then go to FWAIT.
- FWAIT: wait for `mem_rvalid`, capture `mem_rdata`, go to AWRITE.
- AWRITE:
  - One-cycle `acc_wen` with the captured data.
  - `acc_addr` = 4k for A elements; 0x10 + 4(k−VEC_LEN) for B elements.
  - Then k++. If k == 2·VEC_LEN go to TRIGGER, else go to FETCH.
- TRIGGER: one-cycle write of 0x1 to 0x20; go to WAIT_DONE and clear the timeout counter.
- WAIT_DONE:
  - On `acc_done` → RDRES.
  - When the counter reaches TIMEOUT → set `err`, go to FINISH and skip write-back.
- RDRES: one-cycle `acc_ren` at 0x24 → RDCAP.
- RDCAP: capture `acc_rdata` → WBACK.
- WBACK: `mem_req`=1, `mem_we`=1, `mem_addr` = `dst`, `mem_wdata` = result; hold until `mem_ready` → FINISH.
- FINISH: pulse `done` → IDLE.
- `start` is ignored in every state other than IDLE. A `start` arriving in the same cycle as FINISH is lost.
- `mem_rvalid` outside FWAIT is ignored.
- Addresses wrap modulo 2^ADDR_W.
- Unused elements (when VEC_LEN < 4) are not written. The accelerator keeps its previous contents in those registers.

## Timing
- Reset values: every output is 0, including `busy`, `done`, `err` and all strobes and buses. The FSM returns to IDLE.
- Reset asserted mid-job aborts immediately. No `done` is pulsed and no write-back occurs.
- Outputs are registered.
- Per element, with `mem_ready` in the first FETCH cycle and `mem_rvalid` one cycle later, the element costs 3 cycles.
- Job latency from `start` to the `done` pulse, with zero-wait memory and `acc_done` arriving D cycles after TRIGGER: 6·VEC_LEN + D + 5 cycles. This is 29 + D for VEC_LEN = 4.
- `acc_wen` and `acc_ren` are never asserted in the same cycle. `mem_req` is never high while `acc_wen`/`acc_ren` is high.
- `done` and `busy` fall in the same cycle; that cycle is the first IDLE cycle after FINISH.

## Structure
- Shared package `ml_accel_pkg`:
  - Register offsets: `A_BASE`=0x00, `B_BASE`=0x10, `CTRL`=0x20, `RESULT`=0x24.
  - Loader state enum.
  - The `ml_accel` DONE state encoding (2'b10).
- Single module with no sub-module. The timeout counter and the element index are inline registers.

## Test plan
- A=[1,2,3,4] at 0x100 and B=[5,6,7,8] at 0x200, dst=0x300, memory with zero wait, paired with `ml_accel` → memory[0x300]=70, one `done` pulse, `err`=0.
- Same job with `mem_ready` delayed 3 cycles on every request → same result, `mem_addr` stable while the request is held, latency grows by 27 cycles.
- `acc_done` forced low → `err`=1 and `done` after TIMEOUT cycles in WAIT_DONE, no write to 0x300.
- Second `start` pulsed while `busy` → ignored; exactly one job and one `done`.
- `rst` asserted during FETCH of B[1] → all outputs 0 immediately; a new job then completes with 70.
- Check the accelerator address sequence: 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14, 0x18, 0x1C, 0x20 (write), then 0x24 (read).
